// File: rtl/input_port_requester_pkg.sv
// Shared definitions for the router input-port requester: flit_id codes,
// requester FSM states and the saturating flit counter helper.
package input_port_requester_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] ID_HEADER = 3'b001;
  localparam logic [2:0] ID_BODY   = 3'b010;
  localparam logic [2:0] ID_TAIL   = 3'b100;

  typedef enum logic [2:0] {
    REQ_IDLE = 3'b001,
    REQ_WAIT = 3'b010,
    REQ_SEND = 3'b100
  } req_state_e;

  // Packet flit counts stick at the field maximum rather than wrapping.
  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

endpackage

// File: rtl/input_port_requester_flit_fifo.sv
// Synchronous first-word-fall-through flit FIFO; the head entry is always
// presented on rdata, and pushes into a full FIFO or pops from an empty one are ignored.
module flit_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/input_port_requester.sv
// Requester side of the output-port arbitration: buffers flits, requests the
// arbiter when a HEADER reaches the head, and forwards the packet once granted.
module input_port_requester
  import input_port_requester_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 8,
  parameter int LEN_LSB = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_flit,
  input  logic [2:0]        in_id,
  output logic              in_ready,
  input  logic              grant,
  input  logic              out_ready,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [11:0]       length,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_flit,
  output logic              len_err,
  output logic              drop_err
);

  localparam int FW = DATA_W + 3;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0]     head;
  logic [2:0]        head_id;
  logic [DATA_W-1:0] head_flit;
  logic [11:0]       head_len;

  req_state_e  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] len_q, len_d;
  logic        req_q, req_d;
  logic        len_err_q, len_err_d;
  logic        drop_err_q, drop_err_d;

  flit_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata ({in_flit, in_id}),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_id   = head[2:0];
  assign head_flit = head[FW-1:3];
  assign head_len  = head_flit[LEN_LSB+11:LEN_LSB];

  assign in_ready = ~fifo_full;
  assign out_flit = head_flit;
  assign flit_id  = fifo_empty ? 3'b000 : head_id;
  assign length   = (state_q != REQ_SEND && !fifo_empty && head_id == ID_HEADER) ? head_len : len_q;
  assign req      = req_q;
  assign len_err  = len_err_q;
  assign drop_err = drop_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    len_err_d  = 1'b0;
    drop_err_d = 1'b0;
    fifo_pop   = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      REQ_IDLE: begin
        if (!fifo_empty) begin
          if (head_id == ID_HEADER) begin
            state_d = REQ_WAIT;
            len_d   = head_len;
          end else begin
            fifo_pop   = 1'b1;
            drop_err_d = 1'b1;
          end
        end
      end
      REQ_WAIT: begin
        if (grant) state_d = REQ_SEND;
      end
      REQ_SEND: begin
        // A dropped grant simply stalls the packet; the request stays up.
        out_valid = grant & ~fifo_empty;
        if (out_valid && out_ready) begin
          fifo_pop = 1'b1;
          if (head_id == ID_TAIL) begin
            state_d   = REQ_IDLE;
            cnt_d     = '0;
            len_err_d = (sat_inc(cnt_q) != len_q);
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      default: state_d = REQ_IDLE;
    endcase
    req_d = (state_d != REQ_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      req_q      <= 1'b0;
      len_err_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      req_q      <= req_d;
      len_err_q  <= len_err_d;
      drop_err_q <= drop_err_d;
    end
  end

endmodule
